shift_unit: RTL
===============

Name: shift_unit

Overview:
- Parametrised, multi-cycle shifter for the CPU datapath. Generalises the existing fixed 8-bit logical right-shift-by-1.
- Supports a variable shift amount and four modes: logical right, logical left, arithmetic right and rotate right.
- Shifts one bit per clock under a start/busy/done handshake. Produces a carry-out (last bit shifted out) and a zero flag for the status register.

Parameters:
- WIDTH, 8, data width in bits (≥2, power of two).
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount input (so the amount can express WIDTH).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- mode  input  2  00=LSR, 01=LSL, 10=ASR, 11=ROR.
- X  input  WIDTH  operand.
- amount  input  AMT_W  requested shift distance.
- Z  output  WIDTH  result register.
- carry  output  1  last bit shifted out.
- zero  output  1  combinational, (Z == 0).
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, Z=0, carry=0, busy=0, done=0. zero therefore reads 1. Reset overrides everything, including mid-operation; the in-flight result is discarded.
- States are IDLE, SHIFT and DONE.
- IDLE: on start=1, capture X, mode and the effective amount n into internal registers.
  - Effective amount n: for LSR/LSL/ASR, n = min(amount, WIDTH); for ROR, n = amount mod WIDTH.
  - If n=0, go to DONE. Otherwise load count=n, go to SHIFT, and set busy=1.
- SHIFT: every cycle, apply a one-bit shift to the working register and latch the shifted-out bit into an internal carry. count decrements; when count reaches 0, go to DONE.
  - LSR: zero fills the MSB; LSB goes out.
  - LSL: zero fills the LSB; MSB goes out.
  - ASR: MSB is replicated; LSB goes out.
  - ROR: LSB moves to MSB; carry = that bit.
- DONE (one cycle): Z := working register and carry := internal carry, both visible in this cycle; done=1, busy=0. Next state is IDLE.
  - With n=0: Z=X, carry=0.
- Latency: the start edge is cycle 0; done=1 during cycle n+1 (n=0 gives cycle 1). Throughput is one op per n+2 cycles.
- Z and carry hold their value between completions. They do not change while shifting.
- busy=1 exactly in SHIFT. start is ignored while busy=1 or in DONE; X, mode and amount may change freely after capture.
- Clamped amount ≥WIDTH behaviour:
  - LSR/LSL give Z=0, with carry = original MSB (LSR) or LSB (LSL).
  - ASR gives all bits = original MSB, carry = original MSB.
- ROR with amount a multiple of WIDTH gives n=0: Z=X, carry=0.

Test Plan:
- Reset then LSR: X=0xB4, amount=1, mode=00 -> done in cycle 2; Z=0x5A, carry=0, zero=0; busy high for cycle 1 only.
- ASR and LSL:
  - X=0x96, amount=3, mode=10 -> Z=0xF2, carry=1, done in cycle 4.
  - X=0x81, amount=1, mode=01 -> Z=0x02, carry=1.
- ROR wrap and zero amount:
  - X=0x01, amount=9, mode=11 -> n=1, Z=0x80, carry=1, done in cycle 2.
  - X=0x3C, amount=0 -> Z=0x3C, carry=0, done in cycle 1, busy never asserted.
- Clamp: X=0xFF, amount=12, mode=00 -> n=8, Z=0x00, carry=1, zero=1, done in cycle 9.
- Handshake: start LSR X=0x80, amount=4; pulse start with X=0xFF in cycle 2 -> ignored, Z=0x08 in cycle 5, exactly one done pulse.
- Reset mid-op: start LSL X=0x01, amount=6; rst=1 in cycle 3 -> next cycle busy=0, Z=0, carry=0, zero=1, no done pulse; a following start works normally.

Source files
------------

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - multi-cycle one-bit-per-clock shifter with LSR/LSL/ASR/ROR modes
module shift_unit #(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] X,
   input  logic [AMT_W-1:0] amount,
   output logic [WIDTH-1:0] Z,
   output logic             carry,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam int SH_W = $clog2(WIDTH);
   localparam logic [1:0] MODE_LSR = 2'b00;
   localparam logic [1:0] MODE_LSL = 2'b01;
   localparam logic [1:0] MODE_ASR = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;
   localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] work_q, work_nxt;
   logic [1:0]       mode_q, mode_nxt;
   logic [AMT_W-1:0] count_q, count_nxt;
   logic [WIDTH-1:0] z_nxt;
   logic             carry_nxt;
   logic [AMT_W-1:0] n_eff;
   logic [WIDTH-1:0] shifted;
   logic             shift_out;

   // Rotation wraps modulo WIDTH; the linear shifts saturate at WIDTH.
   always_comb begin
      if (mode == MODE_ROR)
         n_eff = {1'b0, amount[SH_W-1:0]};
      else if (amount > WIDTH_AMT)
         n_eff = WIDTH_AMT;
      else
         n_eff = amount;
   end

   always_comb begin
      shifted   = work_q;
      shift_out = 1'b0;
      case (mode_q)
         MODE_LSR: begin
            shifted   = {1'b0, work_q[WIDTH-1:1]};
            shift_out = work_q[0];
         end
         MODE_LSL: begin
            shifted   = {work_q[WIDTH-2:0], 1'b0};
            shift_out = work_q[WIDTH-1];
         end
         MODE_ASR: begin
            shifted   = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            shift_out = work_q[0];
         end
         default: begin
            shifted   = {work_q[0], work_q[WIDTH-1:1]};
            shift_out = work_q[0];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         work_q  <= '0;
         mode_q  <= MODE_LSR;
         count_q <= '0;
         Z       <= '0;
         carry   <= 1'b0;
      end else begin
         state   <= state_nxt;
         work_q  <= work_nxt;
         mode_q  <= mode_nxt;
         count_q <= count_nxt;
         Z       <= z_nxt;
         carry   <= carry_nxt;
      end
   end

   // Z/carry are loaded on the edge entering DONE so they are visible with done.
   always_comb begin
      state_nxt = state;
      work_nxt  = work_q;
      mode_nxt  = mode_q;
      count_nxt = count_q;
      z_nxt     = Z;
      carry_nxt = carry;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               work_nxt  = X;
               mode_nxt  = mode;
               count_nxt = n_eff;
               if (n_eff == '0) begin
                  z_nxt     = X;
                  carry_nxt = 1'b0;
                  state_nxt = DONE;
               end else begin
                  state_nxt = SHIFT;
               end
            end
         end
         SHIFT: begin
            busy      = 1'b1;
            work_nxt  = shifted;
            count_nxt = count_q - AMT_W'(1);
            if (count_q == AMT_W'(1)) begin
               z_nxt     = shifted;
               carry_nxt = shift_out;
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign zero = (Z == '0);

endmodule
